// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Ceiling log2 used at elaboration time. It returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
module adder_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout  = c[DIGIT];
  // Carry into the top bit; XORed with cout it gives signed overflow.
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit with a valid/ready handshake on each side.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NDig = WIDTH / DIGIT;
  localparam int unsigned CntW = (clog2(NDig) > 0) ? clog2(NDig) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NDig - 1);

  if (DIGIT < 1 || WIDTH < 2 || WIDTH > 64 || (WIDTH % DIGIT) != 0) begin : g_param_err
    $fatal(1, "serial_adder: WIDTH must be 2..64 and a multiple of DIGIT");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT-1:0]  dig_sum;
  logic              dig_cout;
  logic              dig_cmsb;

  adder_digit #(
    .DIGIT (DIGIT)
  ) u_adder_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (dig_sum),
    .cout  (dig_cout),
    .c_msb (dig_cmsb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + 1, so the +1 rides in on the carry.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
        carry_d = dig_cout;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          ovf_d   = dig_cmsb ^ dig_cout;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = res_q;
  // The carry register holds the final carry-out once the last digit is done.
  assign c_out     = carry_q;
  assign ovf       = ovf_q;

endmodule
